pll_out_enable_sequencer: RTL

//  Parametrised soft sequencer for a PolarFire PLL in external-feedback mode. Drives PLL POWERDOWN_N
//  and NUM_OUT per-divider output enables; releases outputs only after a filtered, stable lock.

---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/pll_lock_filter.sv | 39 +++
 rtl/pll_out_enable_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL output-enable sequencer.
// The state encoding is visible on the STATE debug port and must stay fixed.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_PWRDN     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_WAIT_EN   = 3'd2,
        ST_RUN       = 3'd3,
        ST_DISABLE   = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    // Saturating increment for the consecutive-failure counter.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Brings the asynchronous PLL LOCK into the FREF domain and qualifies it:
// lock_ok needs a run of synchronised highs and drops on the first synchronised low.
module pll_lock_filter #(
    parameter int LOCK_FILTER = 8
) (
    input  logic fref,
    input  logic reset_n,
    input  logic pll_lock,
    output logic lock_ok
);

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [FILT_W-1:0] FILT_FULL = FILT_W'(LOCK_FILTER);

    logic              sync_meta;
    logic              sync_lock;
    logic [FILT_W-1:0] run_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fref) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_lock <= 1'b0;
            run_cnt   <= '0;
        end else begin
            sync_meta <= pll_lock;
            sync_lock <= sync_meta;
            if (!sync_lock) begin
                run_cnt <= '0;
            end else if (run_cnt != FILT_FULL) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    // Gating with the live synchronised sample makes a lock drop visible without extra delay.
    assign lock_ok = sync_lock && (run_cnt == FILT_FULL);

endmodule

// File: rtl/pll_out_enable_sequencer.sv
// Power-up / enable / retry sequencer for a PLL in external-feedback mode.
// Output enables are only released after a filtered, stable lock and drop immediately on lock loss.
module pll_out_enable_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_OUT         = 2,
    parameter int CNT_W           = 16,
    parameter int PD_CYCLES       = 64,
    parameter int WAIT_EN_CYCLES  = 40000,
    parameter int WAIT_DIS_CYCLES = 40000,
    parameter int LOCK_FILTER     = 8,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int MAX_RETRY       = 3
) (
    input  logic               FREF,
    input  logic               RESET_N,
    input  logic               PLL_LOCK,
    input  logic [NUM_OUT-1:0] OUT_EN_REQ,
    output logic               POWERDOWN_N,
    output logic [NUM_OUT-1:0] OUT_EN,
    output logic               READY,
    output logic               LOCK_LOST,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_CNT,
    output logic [STATE_W-1:0] STATE
);

    localparam longint CNT_SPAN = longint'(1) << CNT_W;

    if (NUM_OUT < 1 || NUM_OUT > 4) begin : g_bad_num_out
        $error("NUM_OUT must be in 1..4");
    end
    if (PD_CYCLES < 1 || WAIT_EN_CYCLES < 1 || WAIT_DIS_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        longint'(PD_CYCLES) > CNT_SPAN || longint'(WAIT_EN_CYCLES) > CNT_SPAN ||
        longint'(WAIT_DIS_CYCLES) > CNT_SPAN || longint'(LOCK_TIMEOUT) > CNT_SPAN) begin : g_bad_cycles
        $error("delay parameters must be in 1..2**CNT_W");
    end
    if (LOCK_FILTER < 1) begin : g_bad_filter
        $error("LOCK_FILTER must be at least 1");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > (2 ** RETRY_W) - 1) begin : g_bad_retry
        $error("MAX_RETRY must fit the retry counter");
    end

    localparam logic [CNT_W-1:0]   PD_LAST     = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   EN_LAST     = CNT_W'(WAIT_EN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DIS_LAST    = CNT_W'(WAIT_DIS_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic lock_ok;

    pll_lock_filter #(
        .LOCK_FILTER(LOCK_FILTER)
    ) u_lock_filter (
        .fref    (FREF),
        .reset_n (RESET_N),
        .pll_lock(PLL_LOCK),
        .lock_ok (lock_ok)
    );

    seq_state_e       state_q;
    seq_state_e       state_d;
    seq_state_e       fail_dest;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic             fail;
    logic             lost_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        fail      = 1'b0;
        fail_dest = ST_PWRDN;
        lost_d    = 1'b0;

        case (state_q)
            ST_PWRDN: begin
                if (cnt_q == PD_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = ST_WAIT_EN;
                end else if (cnt_q == TO_LAST) begin
                    fail      = 1'b1;
                    fail_dest = ST_PWRDN;
                end
            end
            ST_WAIT_EN: begin
                if (!lock_ok) begin
                    fail      = 1'b1;
                    fail_dest = ST_DISABLE;
                end else if (cnt_q == EN_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A lock drop takes precedence over the stable-run retry clear.
                if (!lock_ok) begin
                    lost_d    = 1'b1;
                    fail      = 1'b1;
                    fail_dest = ST_DISABLE;
                end else if (cnt_q == EN_LAST) begin
                    retry_d = '0;
                end
            end
            ST_DISABLE: begin
                if (cnt_q == DIS_LAST) state_d = ST_PWRDN;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_PWRDN;
            end
        endcase

        if (fail) begin
            retry_d = retry_inc(retry_q);
            state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : fail_dest;
        end
    end

    // The counter restarts on every state change and parks once RUN is considered stable.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUN && cnt_q == EN_LAST) || state_q == ST_FAULT) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge FREF) begin
        if (!RESET_N) begin
            state_q     <= ST_PWRDN;
            cnt_q       <= '0;
            retry_q     <= '0;
            POWERDOWN_N <= 1'b0;
            OUT_EN      <= '0;
            READY       <= 1'b0;
            LOCK_LOST   <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            POWERDOWN_N <= state_d inside {ST_WAIT_LOCK, ST_WAIT_EN, ST_RUN, ST_DISABLE};
            READY       <= (state_d == ST_RUN);
            FAULT       <= (state_d == ST_FAULT);
            LOCK_LOST   <= lost_d;
            OUT_EN      <= (state_q == ST_RUN && lock_ok) ? OUT_EN_REQ : '0;
        end
    end

    assign STATE     = state_q;
    assign RETRY_CNT = retry_q;

endmodule
